mux_4x1_arbiter: RTL

MUX_4X1_ARBITER -- requirements
Module: mux_4x1_arbiter

---
 rtl/mux_4x1_arbiter.sv | 129 ++++++++++++
 1 files changed

// File: rtl/mux_4x1_arbiter.sv
// rtl/mux_4x1_arbiter.sv - round-robin 4-requester arbiter driving a shared 4x1 mux
//
// Purpose:
//   Grants one of four requesters ownership of a shared 4x1 data mux.
//   Arbitration is round-robin from a rotating pointer. An owner keeps the
//   grant until it drops its request or has held the grant for MAX_HOLD
//   consecutive cycles. Handover to the next winner happens on the same edge
//   as the release, so there is no dead cycle between owners.
//
// Parameters:
//   MAX_HOLD  maximum consecutive grant cycles per owner (1..15)
//
// Ports:
//   clk    in   1  clock, all state updates on the rising edge
//   rst_n  in   1  asynchronous active-low reset
//   req    in   4  request lines, req[i] = requester i wants the mux
//   a      in   4  mux data, a[i] = requester i's data bit
//   grant  out  4  registered one-hot grant, zero when idle
//   sel    out  2  registered index of the current/last owner
//   busy   out  1  registered, high whenever grant is non-zero
//   y      out  1  combinational mux output, a[sel] when busy else 0

module mux_4x1_arbiter #(
  parameter int MAX_HOLD = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] req,
  input  logic [3:0] a,
  output logic [3:0] grant,
  output logic [1:0] sel,
  output logic       busy,
  output logic       y
);

  // Hold counter only has to reach MAX_HOLD.
  localparam int HW = (MAX_HOLD < 2) ? 1 : $clog2(MAX_HOLD + 1);
  localparam logic [HW-1:0] HOLD_MAX = HW'(MAX_HOLD);
  localparam logic [HW-1:0] HCNT_ONE = HW'(1);

  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_OWNED = 1'b1;

  logic [0:0]    r_state;
  logic [1:0]    r_ptr;
  logic [HW-1:0] r_hcnt;
  logic [3:0]    r_grant;
  logic [1:0]    r_sel;
  logic          r_busy;

  logic          w_owned;
  logic          w_release;
  logic          w_arbitrate;
  logic [1:0]    w_arb_ptr;
  logic [7:0]    w_req_dbl;
  logic [3:0]    w_req_rot;
  logic          w_win_valid;
  logic [1:0]    w_win_off;
  logic [1:0]    w_win_idx;
  logic [3:0]    w_win_onehot;

  assign w_owned = (r_state == ST_OWNED);

  // While owned, r_sel is the owner's index.
  assign w_release   = w_owned && (!req[r_sel] || (r_hcnt == HOLD_MAX));
  assign w_arbitrate = !w_owned || w_release;

  // On release the pointer advances past the owner and arbitration uses the
  // advanced value on the same edge; from idle the stored pointer is used.
  assign w_arb_ptr = w_owned ? (r_sel + 2'd1) : r_ptr;

  // Rotate requests so bit k corresponds to requester (w_arb_ptr + k) mod 4;
  // a fixed priority encoder on the rotated vector is then round-robin.
  assign w_req_dbl = {req, req} >> w_arb_ptr;
  assign w_req_rot = w_req_dbl[3:0];

  always_comb begin
    w_win_valid = 1'b1;
    w_win_off   = 2'd0;
    casez (w_req_rot)
      4'b???1: w_win_off = 2'd0;
      4'b??10: w_win_off = 2'd1;
      4'b?100: w_win_off = 2'd2;
      4'b1000: w_win_off = 2'd3;
      default: w_win_valid = 1'b0;
    endcase
  end

  assign w_win_idx    = w_arb_ptr + w_win_off;
  assign w_win_onehot = 4'b0001 << w_win_idx;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_ptr   <= 2'd0;
      r_hcnt  <= '0;
      r_grant <= 4'b0000;
      r_sel   <= 2'd0;
      r_busy  <= 1'b0;
    end else if (w_arbitrate) begin
      if (w_release) begin
        r_ptr <= r_sel + 2'd1;
      end
      if (w_win_valid) begin
        // A forced release with only the owner requesting lands here with
        // the same index, so grant stays asserted and the count restarts.
        r_state <= ST_OWNED;
        r_grant <= w_win_onehot;
        r_sel   <= w_win_idx;
        r_busy  <= 1'b1;
        r_hcnt  <= HCNT_ONE;
      end else begin
        // sel keeps the last owner's index while idle.
        r_state <= ST_IDLE;
        r_grant <= 4'b0000;
        r_busy  <= 1'b0;
        r_hcnt  <= '0;
      end
    end else begin
      r_hcnt <= r_hcnt + HCNT_ONE;
    end
  end

  assign grant = r_grant;
  assign sel   = r_sel;
  assign busy  = r_busy;
  assign y     = r_busy ? a[r_sel] : 1'b0;

endmodule
